// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex driver for a row of seven-segment digits.
// One shared decoder, a prescaled digit scan and a double-buffered display
// register that only updates at frame boundaries so the display never tears.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_DIV    = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [4*NUM_DIGITS-1:0] iDATA,
    input  logic [NUM_DIGITS-1:0]   iDP,
    input  logic                    iLOAD,
    input  logic                    iBLANK_EN,
    output logic [6:0]              oSEG,
    output logic                    oDP,
    output logic [NUM_DIGITS-1:0]   oAN,
    output logic                    oFRAME
);

    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam int unsigned PTR_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_DIGITS - 1);
    // Level that means "off"/"inactive" on every output pin
    localparam logic OFF = ACTIVE_LOW;

    logic [CNT_W-1:0]      r_cnt;
    logic [PTR_W-1:0]      r_ptr;
    logic [DATA_W-1:0]     r_shadow_data;
    logic [NUM_DIGITS-1:0] r_shadow_dp;
    logic                  r_pending;
    logic [DATA_W-1:0]     r_disp_data;
    logic [NUM_DIGITS-1:0] r_disp_dp;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame;

    logic                  w_tick;
    logic                  w_boundary;
    logic                  w_commit;
    logic [PTR_W-1:0]      w_ptr_nx;
    logic [DATA_W-1:0]     w_shadow_data_nx;
    logic [NUM_DIGITS-1:0] w_shadow_dp_nx;
    logic [DATA_W-1:0]     w_disp_data_nx;
    logic [NUM_DIGITS-1:0] w_disp_dp_nx;
    logic [3:0]            w_nib;
    logic                  w_dp_sel;
    logic [NUM_DIGITS-1:0] w_an_hi;
    logic                  w_zero_run;
    logic                  w_blank;
    logic [6:0]            w_seg_hi;

    // Active-high glyph {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        f_glyph = 7'b0000000;
        case (nib)
            4'h0: f_glyph = 7'b0111111;
            4'h1: f_glyph = 7'b0000110;
            4'h2: f_glyph = 7'b1011011;
            4'h3: f_glyph = 7'b1001111;
            4'h4: f_glyph = 7'b1100110;
            4'h5: f_glyph = 7'b1101101;
            4'h6: f_glyph = 7'b1111101;
            4'h7: f_glyph = 7'b0000111;
            4'h8: f_glyph = 7'b1111111;
            4'h9: f_glyph = 7'b1100111;
            4'hA: f_glyph = 7'b1110111;
            4'hB: f_glyph = 7'b1111100;
            4'hC: f_glyph = 7'b0111001;
            4'hD: f_glyph = 7'b1011110;
            4'hE: f_glyph = 7'b1111001;
            4'hF: f_glyph = 7'b1110001;
            default: f_glyph = 7'b0000000;
        endcase
    endfunction

    // Scan timing and buffer hand-over; a load in the boundary cycle wins over the old shadow
    always_comb begin
        w_tick           = (r_cnt == CNT_LAST);
        w_boundary       = w_tick && (r_ptr == PTR_LAST);
        w_commit         = w_boundary && r_pending;
        w_ptr_nx         = (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
        w_shadow_data_nx = iLOAD ? iDATA : r_shadow_data;
        w_shadow_dp_nx   = iLOAD ? iDP : r_shadow_dp;
        w_disp_data_nx   = w_commit ? w_shadow_data_nx : r_disp_data;
        w_disp_dp_nx     = w_commit ? w_shadow_dp_nx : r_disp_dp;
    end

    // Select the upcoming digit and decide leading-zero blanking from the top down
    always_comb begin
        w_nib      = 4'h0;
        w_dp_sel   = 1'b0;
        w_an_hi    = '0;
        w_zero_run = 1'b1;
        w_blank    = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (w_disp_data_nx[4*i +: 4] == 4'h0);
            if (PTR_W'(i) == w_ptr_nx) begin
                w_nib      = w_disp_data_nx[4*i +: 4];
                w_dp_sel   = w_disp_dp_nx[i];
                w_an_hi[i] = 1'b1;
                w_blank    = iBLANK_EN && (i != 0) && w_zero_run;
            end
        end
        w_seg_hi = w_blank ? 7'b0000000 : f_glyph(w_nib);
    end

    // Prescaler and digit pointer
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_cnt <= '0;
            r_ptr <= PTR_LAST;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_tick) begin
                r_ptr <= w_ptr_nx;
            end
        end
    end

    // Shadow and display registers with pending-load flag
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_pending     <= 1'b0;
            r_disp_data   <= '0;
            r_disp_dp     <= '0;
        end else begin
            r_shadow_data <= w_shadow_data_nx;
            r_shadow_dp   <= w_shadow_dp_nx;
            r_disp_data   <= w_disp_data_nx;
            r_disp_dp     <= w_disp_dp_nx;
            if (iLOAD) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Registered pin drivers, refreshed once per digit slot
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_seg   <= {7{OFF}};
            r_dp    <= OFF;
            r_an    <= {NUM_DIGITS{OFF}};
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            if (w_tick) begin
                r_seg <= w_seg_hi ^ {7{OFF}};
                r_dp  <= w_dp_sel ^ OFF;
                r_an  <= w_an_hi ^ {NUM_DIGITS{OFF}};
            end
        end
    end

    assign oSEG   = r_seg;
    assign oDP    = r_dp;
    assign oAN    = r_an;
    assign oFRAME = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (4-digit active-low, 8-digit
// active-high) checked every cycle against a slot-arithmetic model.
module tb_seg7_scan_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic [15:0] data0 = '0;
    logic [31:0] data1 = '0;
    logic [3:0]  dpi0 = '0;
    logic [7:0]  dpi1 = '0;
    logic        load0 = 1'b0, load1 = 1'b0;
    logic        blank0 = 1'b0, blank1 = 1'b0;
    logic [6:0]  seg0, seg1;
    logic        dpo0, dpo1;
    logic [3:0]  an0;
    logic [7:0]  an1;
    logic        frame0, frame1;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(DIV), .ACTIVE_LOW(1'b1)) u_dut0 (
        .iCLK(clk), .iRST(rst0), .iDATA(data0), .iDP(dpi0), .iLOAD(load0),
        .iBLANK_EN(blank0), .oSEG(seg0), .oDP(dpo0), .oAN(an0), .oFRAME(frame0)
    );

    seg7_scan_driver #(.NUM_DIGITS(8), .CLK_DIV(DIV), .ACTIVE_LOW(1'b0)) u_dut1 (
        .iCLK(clk), .iRST(rst1), .iDATA(data1), .iDP(dpi1), .iLOAD(load1),
        .iBLANK_EN(blank1), .oSEG(seg1), .oDP(dpo1), .oAN(an1), .oFRAME(frame1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'b0111111;  1: return 7'b0000110;
            2: return 7'b1011011;  3: return 7'b1001111;
            4: return 7'b1100110;  5: return 7'b1101101;
            6: return 7'b1111101;  7: return 7'b0000111;
            8: return 7'b1111111;  9: return 7'b1100111;
            10: return 7'b1110111; 11: return 7'b1111100;
            12: return 7'b0111001; 13: return 7'b1011110;
            14: return 7'b1111001; default: return 7'b1110001;
        endcase
    endfunction

    // Model state: cycles since reset, shadow/display values, expected pins
    int          m_age [2];
    logic [31:0] m_sh [2], m_disp [2];
    logic [7:0]  m_shdp [2], m_dispdp [2];
    bit          m_pend [2];
    logic [6:0]  e_seg [2];
    logic        e_dp [2];
    logic [7:0]  e_an [2];
    logic        e_frame [2];

    task automatic model_step(input int u, input logic r, input logic [31:0] d,
                              input logic [7:0] p, input logic ld, input logic bl);
        int          n, k, dig, oh, mask;
        bit          al, committed, blank;
        logic [31:0] sh_new;
        logic [7:0]  shdp_new;
        logic [6:0]  seg;
        n    = (u == 0) ? 4 : 8;
        al   = (u == 0);
        mask = (1 << n) - 1;
        if (r) begin
            m_age[u] = 0; m_sh[u] = '0; m_disp[u] = '0; m_shdp[u] = '0; m_dispdp[u] = '0;
            m_pend[u] = 1'b0;
            e_seg[u] = al ? 7'h7F : 7'h00;
            e_dp[u] = al;
            e_an[u] = al ? 8'(mask) : 8'h00;
            e_frame[u] = 1'b0;
        end else begin
            sh_new    = ld ? d : m_sh[u];
            shdp_new  = ld ? p : m_shdp[u];
            committed = 1'b0;
            e_frame[u] = 1'b0;
            if (m_age[u] % DIV == DIV - 1) begin
                k   = m_age[u] / DIV;
                dig = k % n;
                if (dig == 0 && m_pend[u]) begin
                    m_disp[u] = sh_new; m_dispdp[u] = shdp_new; committed = 1'b1;
                end
                blank = bl && dig > 0 && ((m_disp[u] >> (4 * dig)) == 0);
                seg = blank ? 7'h00 : glyph(int'((m_disp[u] >> (4 * dig)) & 32'hF));
                e_seg[u] = al ? ~seg : seg;
                e_dp[u] = m_dispdp[u][dig] ^ al;
                oh = 1 << dig;
                e_an[u] = al ? 8'(~oh & mask) : 8'(oh);
                e_frame[u] = (dig == 0);
            end
            if (ld) m_pend[u] = 1'b1;
            else if (committed) m_pend[u] = 1'b0;
            m_sh[u] = sh_new; m_shdp[u] = shdp_new;
            m_age[u]++;
        end
    endtask

    // Advance the model on the same edge the DUTs sample
    always @(posedge clk) begin
        model_step(0, rst0, {16'h0, data0}, {4'h0, dpi0}, load0, blank0);
        model_step(1, rst1, data1, dpi1, load1, blank1);
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("seg0", 32'(seg0), 32'(e_seg[0]));
            chk("dp0", 32'(dpo0), 32'(e_dp[0]));
            chk("an0", 32'(an0), 32'(e_an[0]));
            chk("frame0", 32'(frame0), 32'(e_frame[0]));
            chk("seg1", 32'(seg1), 32'(e_seg[1]));
            chk("dp1", 32'(dpo1), 32'(e_dp[1]));
            chk("an1", 32'(an1), 32'(e_an[1]));
            chk("frame1", 32'(frame1), 32'(e_frame[1]));
        end
    end

    task automatic wait_frame(input int u);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (((u == 0) ? frame0 : frame1) === 1'b1) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL frame_timeout inst%0d: got no frame pulse, expected one within 200 cycles", u);
    endtask

    initial begin
        int per;
        // Reset for two edges, then release mid-cycle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        chk("rst_an0", 32'(an0), 32'h0F);
        chk("rst_seg0", 32'(seg0), 32'h7F);
        chk("rst_an1", 32'(an1), 32'h00);
        chk("rst_seg1", 32'(seg1), 32'h00);
        repeat (3) begin
            @(negedge clk);
            chk("hold_an0", 32'(an0), 32'h0F);
        end
        @(negedge clk);
        chk("first_an0", 32'(an0), 32'b1110);
        chk("first_seg0", 32'(seg0), 32'b1000000);
        chk("first_frame0", 32'(frame0), 32'h1);

        // 1A2F appears after the next boundary
        wait_frame(0);
        data0 = 16'h1A2F; load0 = 1'b1;
        @(negedge clk); load0 = 1'b0;
        wait_frame(0);
        chk("d0_an", 32'(an0), 32'b1110);   chk("d0_seg", 32'(seg0), 32'b0001110);
        repeat (DIV) @(negedge clk);
        chk("d1_an", 32'(an0), 32'b1101);   chk("d1_seg", 32'(seg0), 32'b0100100);
        repeat (DIV) @(negedge clk);
        chk("d2_an", 32'(an0), 32'b1011);   chk("d2_seg", 32'(seg0), 32'b0001000);
        repeat (DIV) @(negedge clk);
        chk("d3_an", 32'(an0), 32'b0111);   chk("d3_seg", 32'(seg0), 32'b1111001);

        // Load 0000, then 1234 in the boundary cycle itself
        wait_frame(0);
        data0 = 16'h0000; load0 = 1'b1;
        @(negedge clk); load0 = 1'b0;
        repeat (14) @(negedge clk);
        data0 = 16'h1234; load0 = 1'b1;
        @(negedge clk); load0 = 1'b0;
        chk("race_frame", 32'(frame0), 32'h1);
        chk("race_d0", 32'(seg0), 32'b0011001);
        repeat (DIV) @(negedge clk);
        chk("race_d1", 32'(seg0), 32'b0110000);

        // Leading-zero blanking with a DP on the top digit
        blank0 = 1'b1;
        wait_frame(0);
        data0 = 16'h0050; dpi0 = 4'b1000; load0 = 1'b1;
        @(negedge clk); load0 = 1'b0;
        wait_frame(0);
        chk("lz_d0", 32'(seg0), 32'b1000000); chk("lz_dp0", 32'(dpo0), 32'h1);
        repeat (DIV) @(negedge clk);
        chk("lz_d1", 32'(seg0), 32'b0010010);
        repeat (DIV) @(negedge clk);
        chk("lz_d2", 32'(seg0), 32'b1111111);
        repeat (DIV) @(negedge clk);
        chk("lz_d3", 32'(seg0), 32'b1111111); chk("lz_dp3", 32'(dpo0), 32'h0);
        blank0 = 1'b0; dpi0 = 4'b0000;

        // Mid-frame reset drops a pending load
        wait_frame(0);
        data0 = 16'hBEEF; load0 = 1'b1;
        @(negedge clk); load0 = 1'b0;
        repeat (4) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        chk("mrst_an", 32'(an0), 32'h0F);
        chk("mrst_seg", 32'(seg0), 32'h7F);
        chk("mrst_dp", 32'(dpo0), 32'h1);
        chk("mrst_frame", 32'(frame0), 32'h0);
        wait_frame(0);
        chk("mrst_zero", 32'(seg0), 32'b1000000);

        // 8-digit active-high instance: frame period and slot 7 glyph
        wait_frame(1);
        data1 = 32'h89ABCDEF; load1 = 1'b1;
        @(negedge clk); load1 = 1'b0;
        wait_frame(1);
        chk("w_d0_seg", 32'(seg1), 32'b1110001);
        chk("w_d0_an", 32'(an1), 32'h01);
        repeat (28) @(negedge clk);
        chk("w_d7_seg", 32'(seg1), 32'b1111111);
        chk("w_d7_an", 32'(an1), 32'h80);
        per = 28;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            per++;
            if (frame1 === 1'b1) break;
        end
        chk("w_period", 32'(per), 32'd32);

        // Randomized traffic on both instances, including rare resets
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            load0 = ($urandom_range(0, 5) == 0);
            data0 = 16'($urandom) >> $urandom_range(0, 16);
            dpi0  = 4'($urandom);
            if ($urandom_range(0, 19) == 0) blank0 = ~blank0;
            rst0  = ($urandom_range(0, 399) == 0);
            load1 = ($urandom_range(0, 5) == 0);
            data1 = 32'($urandom) >> $urandom_range(0, 32);
            dpi1  = 8'($urandom);
            if ($urandom_range(0, 19) == 0) blank1 = ~blank1;
            rst1  = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0; load0 = 1'b0; load1 = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed hexadecimal driver for a row of common-anode/common-cathode seven-segment digits. It replaces per-digit combinational decoders with one shared decoder, a prescaled scan counter and a double-buffered display register. Loads take effect only at frame boundaries, so the display never tears. It sits between any register/counter datapath and the board display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8).
- CLK_DIV, 50000, clock cycles per digit slot (≥2).
- ACTIVE_LOW, 1, 1: segment/DP/anode outputs are active-low; 0: active-high.
- iCLK  in  1  single system clock; all logic on rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iDATA  in  4*NUM_DIGITS  hex nibbles; nibble i = iDATA[4i+3:4i]; digit 0 is least significant.
- iDP  in  NUM_DIGITS  decimal point per digit.
- iLOAD  in  1  one-cycle strobe capturing iDATA/iDP into the shadow register.
- iBLANK_EN  in  1  enables leading-zero blanking (sampled every cycle).
- oSEG  out  7  segments {g,f,e,d,c,b,a}, bit 6 = g, bit 0 = a.
- oDP  out  1  decimal point of the currently driven digit.
- oAN  out  NUM_DIGITS  one-hot digit select (polarity per ACTIVE_LOW).
- oFRAME  out  1  one-cycle pulse when digit 0 becomes driven.

## Operation
- Prescaler: counts 0..CLK_DIV-1, wraps; tick asserted in the cycle count == CLK_DIV-1.
- Digit pointer: resets to NUM_DIGITS-1; on tick advances by 1, wrapping NUM_DIGITS-1 -> 0. Frame boundary = tick with pointer == NUM_DIGITS-1.
- Shadow register: on iLOAD, captures iDATA and iDP and sets pending.
- Display register: at a frame boundary with pending set, takes the shadow contents and clears pending. An iLOAD in the same cycle overwrites the shadow and leaves pending set. The display register updates no earlier than the next frame boundary.
- Decoder, active-high glyphs {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1100111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - With ACTIVE_LOW=1, the output is the bitwise inverse (0 = 1000000).
- Leading-zero blanking: with iBLANK_EN=1, digit i>0 is blanked (all segments off) when nibbles i..NUM_DIGITS-1 of the display register are all zero. Digit 0 is never blanked. The DP is still driven per iDP.
- Only the selected digit's anode is active; all others are inactive.

## Timing
- Reset values:
  - prescaler 0, pointer NUM_DIGITS-1.
  - shadow, display and pending all 0.
  - oAN all inactive, oSEG all off, oDP off, oFRAME 0. "Off"/"inactive" is level 1 when ACTIVE_LOW=1 and 0 otherwise.
- Outputs stay in the reset state until the first tick, which occurs CLK_DIV cycles after reset release and is a frame boundary.
- All outputs are registered. In the cycle after a tick, oAN/oSEG/oDP reflect the new pointer using the display register value written by that same tick.
- oFRAME is high for exactly the one cycle in which outputs first show digit 0.
- Load latency: from iLOAD to visible data is at least 1 and at most NUM_DIGITS*CLK_DIV+1 cycles.
- iRST asserted mid-frame takes effect at the next edge and restores every reset value, including dropping any pending load.
- iBLANK_EN changes are applied at the next digit-slot output update.

## Test plan
- NUM_DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1, hold iRST 2 cycles. Required: oAN=1111 and oSEG=1111111 for 4 cycles after release, then oAN=1110, oSEG=1000000, oFRAME pulse.
- iDATA=16'h1A2F with iLOAD. Required: after the next frame boundary, slots show oAN 1110/1101/1011/0111 with oSEG 0001110/0100100/0001000/1111001.
- iLOAD 16'h0000, then iLOAD 16'h1234 in the frame-boundary cycle. Required: the frame shows 1,2,3,4; 0000 never appears.
- iBLANK_EN=1, data 16'h0050, iDP=4'b1000. Required: digit 3 segments off with oDP active, digit 2 blank, digit 1 = 5, digit 0 = 0.
- ACTIVE_LOW=0, NUM_DIGITS=8, data 32'h89ABCDEF. Required: one-hot active-high oAN cycling through 8 slots, oSEG(8)=1111111 at slot 7, oFRAME period 32 cycles.
- Assert iRST mid-frame with a load pending. Required: the next cycle shows all reset values, and the display shows 0 after restart.
